// File: rtl/ql_episode_ctrl_pkg.sv
// Shared widths and FSM encoding for the Q-learning episode controller.
package ql_episode_ctrl_pkg;

    localparam int unsigned COUNTER_WIDTH = 8;
    localparam int unsigned STATES_WIDTH  = 4;
    localparam int unsigned ACTIONS_WIDTH = 2;
    localparam int unsigned LFSR_WIDTH    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAdvance,
        StFinish
    } state_e;

endpackage

// File: rtl/ql_lfsr_action.sv
// Free-running 16-bit Fibonacci LFSR with modulo reduction to a random action index.
module ql_lfsr_action
    import ql_episode_ctrl_pkg::*;
#(
    parameter int unsigned            NUM_ACTIONS = 3,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED   = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re_random,
    output logic [ACTIONS_WIDTH-1:0] at_random
);

    logic [LFSR_WIDTH-1:0]    lfsr_q;
    logic                     init_q;
    logic                     feedback;
    logic [ACTIONS_WIDTH-1:0] raw;
    logic [ACTIONS_WIDTH-1:0] reduced;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        raw      = lfsr_q[ACTIONS_WIDTH-1:0];
        // A single subtraction suffices because the raw range is below 2*NUM_ACTIONS.
        reduced  = (raw < ACTIONS_WIDTH'(NUM_ACTIONS)) ? raw : raw - ACTIONS_WIDTH'(NUM_ACTIONS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= LFSR_SEED;
            init_q    <= 1'b1;
            at_random <= '0;
        end else begin
            lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], feedback};
            init_q <= 1'b0;
            // init_q takes one sample on the first cycle out of reset.
            if (init_q || re_random) begin
                at_random <= reduced;
            end
        end
    end

endmodule

// File: rtl/ql_episode_ctrl.sv
// Sequences training episodes/steps for the Q-learning datapath and supplies random actions.
module ql_episode_ctrl
    import ql_episode_ctrl_pkg::*;
#(
    parameter int unsigned           MAX_EPISODES = 16,
    parameter int unsigned           MAX_STEPS    = 8,
    parameter int unsigned           NUM_STATES   = 16,
    parameter int unsigned           NUM_ACTIONS  = 3,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_dtp_valid,
    input  logic                     i_re_random,
    output logic                     o_valid,
    output logic                     o_write_file_en,
    output logic [COUNTER_WIDTH-1:0] o_count,
    output logic [COUNTER_WIDTH-1:0] o_step,
    output logic [STATES_WIDTH-1:0]  o_first_st,
    output logic [ACTIONS_WIDTH-1:0] o_at_random,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [COUNTER_WIDTH-1:0] LastEp    = COUNTER_WIDTH'(MAX_EPISODES - 1);
    localparam logic [COUNTER_WIDTH-1:0] LastStep  = COUNTER_WIDTH'(MAX_STEPS - 1);
    localparam logic [STATES_WIDTH-1:0]  LastState = STATES_WIDTH'(NUM_STATES - 1);

    state_e                   state_q;
    logic                     valid_q;
    logic                     wfe_q;
    logic                     busy_q;
    logic                     done_q;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] step_q;
    logic [STATES_WIDTH-1:0]  first_q;

    // Registered outputs are set on the transition into the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            wfe_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            step_q  <= '0;
            first_q <= '0;
        end else begin
            valid_q <= 1'b0;
            wfe_q   <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                        wfe_q   <= (LastEp == '0) && (LastStep == '0);
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        step_q  <= '0;
                        first_q <= '0;
                    end
                end
                StIssue: state_q <= StWait;
                StWait: begin
                    if (i_dtp_valid) begin
                        state_q <= StAdvance;
                    end
                end
                StAdvance: begin
                    if (step_q < LastStep) begin
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                        wfe_q   <= (count_q == LastEp) && (step_q + 1'b1 == LastStep);
                        step_q  <= step_q + 1'b1;
                    end else if (count_q < LastEp) begin
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                        wfe_q   <= (count_q + 1'b1 == LastEp) && (LastStep == '0);
                        step_q  <= '0;
                        count_q <= count_q + 1'b1;
                        first_q <= (first_q == LastState) ? '0 : first_q + 1'b1;
                    end else begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_valid         = valid_q;
    assign o_write_file_en = wfe_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_count         = count_q;
    assign o_step          = step_q;
    assign o_first_st      = first_q;

    ql_lfsr_action #(
        .NUM_ACTIONS (NUM_ACTIONS),
        .LFSR_SEED   (LFSR_SEED)
    ) u_lfsr_action (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_random (i_re_random),
        .at_random (o_at_random)
    );

endmodule

// File: tb/tb_ql_episode_ctrl.sv
// Directed bench: a 2x3 run, a 3x1 run with state wrap, random-action range, early/late
// datapath completion, issue spacing and mid-run reset.
module tb_ql_episode_ctrl;
    import ql_episode_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                     start1 = 0, dtp1 = 0, rr1 = 0;
    logic                     valid1, wfe1, busy1, done1;
    logic [COUNTER_WIDTH-1:0] count1, step1;
    logic [STATES_WIDTH-1:0]  first1;
    logic [ACTIONS_WIDTH-1:0] rnd1;

    logic                     start2 = 0, dtp2 = 0, rr2 = 0;
    logic                     valid2, wfe2, busy2, done2;
    logic [COUNTER_WIDTH-1:0] count2, step2;
    logic [STATES_WIDTH-1:0]  first2;
    logic [ACTIONS_WIDTH-1:0] rnd2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ql_episode_ctrl #(
        .MAX_EPISODES (2),
        .MAX_STEPS    (3),
        .NUM_STATES   (16),
        .NUM_ACTIONS  (3),
        .LFSR_SEED    (16'hACE1)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start1),
        .i_dtp_valid     (dtp1),
        .i_re_random     (rr1),
        .o_valid         (valid1),
        .o_write_file_en (wfe1),
        .o_count         (count1),
        .o_step          (step1),
        .o_first_st      (first1),
        .o_at_random     (rnd1),
        .o_busy          (busy1),
        .o_done          (done1)
    );

    ql_episode_ctrl #(
        .MAX_EPISODES (3),
        .MAX_STEPS    (1),
        .NUM_STATES   (2),
        .NUM_ACTIONS  (3),
        .LFSR_SEED    (16'hACE1)
    ) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start2),
        .i_dtp_valid     (dtp2),
        .i_re_random     (rr2),
        .o_valid         (valid2),
        .o_write_file_en (wfe2),
        .o_count         (count2),
        .o_step          (step2),
        .o_first_st      (first2),
        .o_at_random     (rnd2),
        .o_busy          (busy2),
        .o_done          (done2)
    );

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({valid1, wfe1, done1, busy1} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {valid1, wfe1, done1, busy1});
        end
        total++;
        if ({count1, step1, first1, rnd1} !== '0) begin
            bad++;
            $display("FAIL reset_values: got count=%0d step=%0d first=%0d rnd=%0d want all 0",
                     count1, step1, first1, rnd1);
        end
        total++;
        if ({valid2, busy2, count2, first2} !== '0) begin
            bad++;
            $display("FAIL reset_dut2: got valid=%b busy=%b count=%0d first=%0d want 0",
                     valid2, busy2, count2, first2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({valid1, busy1} !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_start: got valid=%b busy=%b want 0 0", valid1, busy1);
        end
    endtask

    task automatic test_full_run();
        int n_issue = 0;
        int n_done = 0;
        int pend = 0;
        int stray_wfe = 0;
        int bad_rnd = 0;
        bit finished = 0;
        logic [COUNTER_WIDTH-1:0] cs[6];
        logic [COUNTER_WIDTH-1:0] ss[6];
        logic [STATES_WIDTH-1:0]  fs[6];
        logic                     ws[6];
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            dtp1 = 1'b0;
            start1 = (cyc == 5);  // must be ignored mid-run
            if (pend > 0) begin
                pend--;
                if (pend == 0) dtp1 = 1'b1;
            end
            if (valid1) begin
                if (n_issue < 6) begin
                    cs[n_issue] = count1;
                    ss[n_issue] = step1;
                    fs[n_issue] = first1;
                    ws[n_issue] = wfe1;
                end
                n_issue++;
                pend = 2;
            end else if (wfe1) begin
                stray_wfe++;
            end
            if (rnd1 > 2'd2) bad_rnd++;
            if (done1) n_done++;
            if (n_done > 0 && !busy1) finished = 1;
            if (!finished) @(negedge clk);
        end
        start1 = 1'b0;
        dtp1 = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL run_timeout: got unfinished after 200 cycles want finished");
        end
        total++;
        if (n_issue != 6) begin
            bad++;
            $display("FAIL run_issue_count: got %0d want 6", n_issue);
        end
        for (int i = 0; i < 6 && i < n_issue; i++) begin
            total++;
            if ({cs[i], ss[i]} !== {COUNTER_WIDTH'(i / 3), COUNTER_WIDTH'(i % 3)}) begin
                bad++;
                $display("FAIL run_index_%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, cs[i], ss[i], i / 3, i % 3);
            end
            total++;
            if (fs[i] !== STATES_WIDTH'(i / 3)) begin
                bad++;
                $display("FAIL run_first_st_%0d: got %0d want %0d", i, fs[i], i / 3);
            end
            total++;
            if (ws[i] !== (i == 5)) begin
                bad++;
                $display("FAIL run_wfe_%0d: got %b want %b", i, ws[i], i == 5);
            end
        end
        total++;
        if (stray_wfe != 0) begin
            bad++;
            $display("FAIL run_wfe_stray: got %0d want 0", stray_wfe);
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL run_done_count: got %0d want 1", n_done);
        end
        total++;
        if ({count1, step1} !== {8'd1, 8'd2}) begin
            bad++;
            $display("FAIL run_retain: got (%0d,%0d) want (1,2)", count1, step1);
        end
        total++;
        if (bad_rnd != 0) begin
            bad++;
            $display("FAIL run_rnd_range: got %0d out-of-range samples want 0", bad_rnd);
        end
    endtask

    task automatic test_wrap();
        int n_issue = 0;
        int n_done = 0;
        int pend = 0;
        bit finished = 0;
        logic [STATES_WIDTH-1:0] fs[3];
        logic                    ws[3];
        logic [STATES_WIDTH-1:0] exp_f[3];
        logic                    exp_w[3];
        exp_f = '{4'd0, 4'd1, 4'd0};
        exp_w = '{1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            dtp2 = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) dtp2 = 1'b1;
            end
            if (valid2) begin
                if (n_issue < 3) begin
                    fs[n_issue] = first2;
                    ws[n_issue] = wfe2;
                end
                n_issue++;
                pend = 1;
            end
            if (done2) n_done++;
            if (n_done > 0 && !busy2) finished = 1;
            if (!finished) @(negedge clk);
        end
        dtp2 = 1'b0;
        total++;
        if (n_issue != 3 || !finished) begin
            bad++;
            $display("FAIL wrap_issue_count: got %0d finished=%b want 3 finished=1",
                     n_issue, finished);
        end
        for (int i = 0; i < 3 && i < n_issue; i++) begin
            total++;
            if (fs[i] !== exp_f[i]) begin
                bad++;
                $display("FAIL wrap_first_st_%0d: got %0d want %0d", i, fs[i], exp_f[i]);
            end
            total++;
            if (ws[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL wrap_wfe_%0d: got %b want %b", i, ws[i], exp_w[i]);
            end
        end
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL wrap_done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_random();
        int out_of_range = 0;
        int hold_bad = 0;
        bit seen[3];
        logic [ACTIONS_WIDTH-1:0] held;
        seen = '{0, 0, 0};
        @(negedge clk);
        rr1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rnd1 > 2'd2) out_of_range++;
            else seen[rnd1] = 1;
        end
        rr1 = 1'b0;
        @(negedge clk);
        held = rnd1;
        repeat (6) begin
            @(negedge clk);
            if (rnd1 !== held) hold_bad++;
        end
        total++;
        if (out_of_range != 0) begin
            bad++;
            $display("FAIL rnd_range: got %0d samples above 2 want 0", out_of_range);
        end
        for (int v = 0; v < 3; v++) begin
            total++;
            if (!seen[v]) begin
                bad++;
                $display("FAIL rnd_seen_%0d: got never seen want seen", v);
            end
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL rnd_hold: got %0d changes while idle want 0", hold_bad);
        end
    endtask

    // Completion coinciding with o_valid is ignored; then a same-cycle answer in WAIT
    // gives the minimum 3-cycle issue spacing.
    task automatic test_early_valid_back_to_back();
        int stray = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        total++;
        if (valid1 !== 1'b1) begin
            bad++;
            $display("FAIL early_first_issue: got valid=%b want 1", valid1);
        end
        dtp1 = 1'b1;
        @(negedge clk);
        dtp1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (valid1 || step1 != 8'd0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL early_ignored: got %0d early advances want 0", stray);
        end
        dtp1 = 1'b1;
        @(negedge clk);
        dtp1 = 1'b0;
        @(negedge clk);
        total++;
        if (valid1 !== 1'b1 || step1 !== 8'd1) begin
            bad++;
            $display("FAIL late_completion: got valid=%b step=%0d want valid=1 step=1",
                     valid1, step1);
        end
        @(negedge clk);
        dtp1 = 1'b1;
        @(negedge clk);
        dtp1 = 1'b0;
        total++;
        if (valid1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got valid=%b in advance cycle want 0", valid1);
        end
        @(negedge clk);
        total++;
        if (valid1 !== 1'b1 || step1 !== 8'd2) begin
            bad++;
            $display("FAIL b2b_latency: got valid=%b step=%0d want valid=1 step=2",
                     valid1, step1);
        end
        pulse_reset();
    endtask

    task automatic test_mid_reset();
        int pend = 0;
        int dones = 0;
        int stray = 0;
        bit found = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int cyc = 0; cyc < 60 && !found; cyc++) begin
            dtp1 = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) dtp1 = 1'b1;
            end
            if (valid1) begin
                if (count1 == 8'd0 && step1 == 8'd1) found = 1;
                pend = 2;
            end
            if (!found) @(negedge clk);
        end
        dtp1 = 1'b0;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_reach_0_1: got not reached want issue (0,1)");
        end
        @(negedge clk);  // now in WAIT of (0,1)
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({valid1, wfe1, done1, busy1, count1, step1, first1, rnd1} !== '0) begin
            bad++;
            $display("FAIL mid_async_clear: got busy=%b count=%0d step=%0d rnd=%0d want 0",
                     busy1, count1, step1, rnd1);
        end
        repeat (3) begin
            @(negedge clk);
            if (done1) dones++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done1) dones++;
            if (valid1 || busy1) stray++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL mid_no_done: got %0d done pulses want 0", dones);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL mid_no_autostart: got %0d active cycles want 0", stray);
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        total++;
        if (valid1 !== 1'b1 || count1 !== 8'd0 || step1 !== 8'd0) begin
            bad++;
            $display("FAIL mid_restart: got valid=%b (%0d,%0d) want valid=1 (0,0)",
                     valid1, count1, step1);
        end
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_wrap();
        test_random();
        test_early_valid_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
